// File: rtl/clock_pkg.sv
// Shared limits, time/date types and calendar helpers for the digital-clock core.
package clock_pkg;

    localparam logic [7:0]  MAX_SEC       = 8'd59;
    localparam logic [7:0]  MAX_MIN       = 8'd59;
    localparam logic [7:0]  MAX_HOUR      = 8'd23;
    localparam logic [7:0]  MAX_TIMER_MIN = 8'd99;
    localparam logic [17:0] SEC_PER_DAY   = 18'd86400;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
        logic [7:0] sec;
    } hms_t;

    function automatic logic is_leap(input logic [15:0] year);
        return ((year % 16'd4 == 16'd0) && (year % 16'd100 != 16'd0)) ||
               (year % 16'd400 == 16'd0);
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic [15:0] year);
        logic [7:0] len;
        case (month)
            8'd2:                      len = is_leap(year) ? 8'd29 : 8'd28;
            8'd4, 8'd6, 8'd9, 8'd11:   len = 8'd30;
            default:                   len = 8'd31;
        endcase
        return len;
    endfunction

    function automatic logic hms_valid(input hms_t t);
        return (t.hour <= MAX_HOUR) && (t.min <= MAX_MIN) && (t.sec <= MAX_SEC);
    endfunction

    // Wraps modulo one day; n is expected to be below SEC_PER_DAY.
    function automatic hms_t add_seconds_hms(input hms_t t, input logic [17:0] n);
        logic [17:0] total;
        hms_t        res;
        total = {10'd0, t.hour} * 18'd3600 + {10'd0, t.min} * 18'd60 + {10'd0, t.sec} + n;
        if (total >= SEC_PER_DAY)
            total = total - SEC_PER_DAY;
        res.hour = 8'(total / 18'd3600);
        res.min  = 8'((total % 18'd3600) / 18'd60);
        res.sec  = 8'(total % 18'd60);
        return res;
    endfunction

endpackage

// File: rtl/date_counter.sv
// Gregorian day/month/year register with leap-aware rollover and validated loading.
module date_counter
    import clock_pkg::*;
#(
    parameter logic [15:0] RESET_YEAR = 16'd2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        day_tick,
    input  logic        set_date,
    input  logic [7:0]  input_day,
    input  logic [7:0]  input_month,
    input  logic [15:0] input_year,
    output logic [7:0]  current_day,
    output logic [7:0]  current_month,
    output logic [15:0] current_year
);

    logic [7:0]  r_day;
    logic [7:0]  r_month;
    logic [15:0] r_year;
    logic        w_set_valid;
    logic        w_month_end;

    assign w_set_valid = set_date &&
                         (input_month >= 8'd1) && (input_month <= 8'd12) &&
                         (input_day >= 8'd1) &&
                         (input_day <= days_in_month(input_month, input_year));
    assign w_month_end = (r_day >= days_in_month(r_month, r_year));

    // A valid load takes precedence over a coincident midnight tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_day   <= 8'd1;
            r_month <= 8'd1;
            r_year  <= RESET_YEAR;
        end else if (w_set_valid) begin
            r_day   <= input_day;
            r_month <= input_month;
            r_year  <= input_year;
        end else if (day_tick) begin
            if (!w_month_end) begin
                r_day <= r_day + 8'd1;
            end else begin
                r_day <= 8'd1;
                if (r_month == 8'd12) begin
                    r_month <= 8'd1;
                    r_year  <= r_year + 16'd1;
                end else begin
                    r_month <= r_month + 8'd1;
                end
            end
        end
    end

    assign current_day   = r_day;
    assign current_month = r_month;
    assign current_year  = r_year;

endmodule

// File: rtl/main_driver.sv
// Digital-clock core: 1 Hz time of day, calendar, 12/24 h view, snoozable alarm, countdown timer.
module main_driver
    import clock_pkg::*;
#(
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned RESET_YEAR = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hour_format,
    input  logic        set_time,
    input  logic        set_date,
    input  logic        set_alarm,
    input  logic        set_timer,
    input  logic        snooze_alarm,
    input  logic        stop_alarm,
    input  logic        start_timer,
    input  logic        stop_timer,
    input  logic [7:0]  input_sec,
    input  logic [7:0]  input_min,
    input  logic [7:0]  input_hour,
    input  logic [7:0]  input_day,
    input  logic [7:0]  input_month,
    input  logic [15:0] input_year,
    input  logic [7:0]  alarm_input_sec,
    input  logic [7:0]  alarm_input_min,
    input  logic [7:0]  alarm_input_hour,
    input  logic [7:0]  timer_input_min,
    input  logic [7:0]  timer_input_sec,
    output logic [7:0]  current_24_sec,
    output logic [7:0]  current_24_min,
    output logic [7:0]  current_24_hour,
    output logic [7:0]  display_sec,
    output logic [7:0]  display_min,
    output logic [7:0]  display_hour,
    output logic [7:0]  current_day,
    output logic [7:0]  current_month,
    output logic [15:0] current_year,
    output logic [7:0]  timer_min,
    output logic [7:0]  timer_sec,
    output logic        timer_running,
    output logic        timer_buzzer,
    output logic        alarm_buzzer
);

    logic [7:0] r_sec, r_min, r_hour;
    hms_t       r_alarm;
    logic       r_alarm_armed, r_alarm_buzzer;
    logic [7:0] r_tmr_min, r_tmr_sec;
    logic       r_tmr_running, r_tmr_buzzer;

    hms_t       w_current, w_time_in, w_alarm_in, w_snooze_time;
    logic       w_time_valid, w_alarm_valid, w_timer_valid;
    logic       w_day_end, w_day_tick, w_alarm_match;
    logic       w_timer_zero, w_timer_last;

    assign w_current     = '{hour: r_hour, min: r_min, sec: r_sec};
    assign w_time_in     = '{hour: input_hour, min: input_min, sec: input_sec};
    assign w_alarm_in    = '{hour: alarm_input_hour, min: alarm_input_min, sec: alarm_input_sec};
    assign w_time_valid  = set_time && hms_valid(w_time_in);
    assign w_alarm_valid = set_alarm && hms_valid(w_alarm_in);
    assign w_timer_valid = set_timer && (timer_input_min <= MAX_TIMER_MIN) && (timer_input_sec <= MAX_SEC);
    assign w_day_end     = (r_sec == MAX_SEC) && (r_min == MAX_MIN) && (r_hour == MAX_HOUR);
    assign w_day_tick    = !reset && !w_time_valid && w_day_end;
    assign w_snooze_time = add_seconds_hms(w_current, 18'(SNOOZE_SEC % 86400));
    assign w_alarm_match = r_alarm_armed && (r_alarm == w_current);
    assign w_timer_zero  = (r_tmr_min == 8'd0) && (r_tmr_sec == 8'd0);
    assign w_timer_last  = (r_tmr_min == 8'd0) && (r_tmr_sec == 8'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sec  <= 8'd0;
            r_min  <= 8'd0;
            r_hour <= 8'd0;
        end else if (w_time_valid) begin
            r_sec  <= input_sec;
            r_min  <= input_min;
            r_hour <= input_hour;
        end else if (r_sec == MAX_SEC) begin
            r_sec <= 8'd0;
            if (r_min == MAX_MIN) begin
                r_min  <= 8'd0;
                r_hour <= (r_hour == MAX_HOUR) ? 8'd0 : r_hour + 8'd1;
            end else begin
                r_min <= r_min + 8'd1;
            end
        end else begin
            r_sec <= r_sec + 8'd1;
        end
    end

    date_counter #(
        .RESET_YEAR (16'(RESET_YEAR))
    ) u_date (
        .clk           (clk),
        .reset         (reset),
        .day_tick      (w_day_tick),
        .set_date      (set_date),
        .input_day     (input_day),
        .input_month   (input_month),
        .input_year    (input_year),
        .current_day   (current_day),
        .current_month (current_month),
        .current_year  (current_year)
    );

    // Snooze only acts while buzzing; stop takes priority over it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alarm        <= '0;
            r_alarm_armed  <= 1'b0;
            r_alarm_buzzer <= 1'b0;
        end else if (w_alarm_valid) begin
            r_alarm        <= w_alarm_in;
            r_alarm_armed  <= 1'b1;
            r_alarm_buzzer <= 1'b0;
        end else if (stop_alarm) begin
            r_alarm_armed  <= 1'b0;
            r_alarm_buzzer <= 1'b0;
        end else if (snooze_alarm && r_alarm_buzzer) begin
            r_alarm        <= w_snooze_time;
            r_alarm_buzzer <= 1'b0;
        end else if (w_alarm_match) begin
            r_alarm_buzzer <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmr_min     <= 8'd0;
            r_tmr_sec     <= 8'd0;
            r_tmr_running <= 1'b0;
            r_tmr_buzzer  <= 1'b0;
        end else if (w_timer_valid) begin
            r_tmr_min     <= timer_input_min;
            r_tmr_sec     <= timer_input_sec;
            r_tmr_running <= 1'b0;
            r_tmr_buzzer  <= 1'b0;
        end else if (stop_timer) begin
            r_tmr_running <= 1'b0;
            r_tmr_buzzer  <= 1'b0;
        end else if (r_tmr_running) begin
            if (r_tmr_sec == 8'd0) begin
                r_tmr_sec <= MAX_SEC;
                r_tmr_min <= r_tmr_min - 8'd1;
            end else begin
                r_tmr_sec <= r_tmr_sec - 8'd1;
            end
            if (w_timer_last) begin
                r_tmr_running <= 1'b0;
                r_tmr_buzzer  <= 1'b1;
            end
        end else if (start_timer && !w_timer_zero) begin
            r_tmr_running <= 1'b1;
        end
    end

    always_comb begin
        display_hour = r_hour;
        if (hour_format) begin
            if (r_hour == 8'd0)
                display_hour = 8'd12;
            else if (r_hour > 8'd12)
                display_hour = r_hour - 8'd12;
        end
    end

    assign display_sec     = r_sec;
    assign display_min     = r_min;
    assign current_24_sec  = r_sec;
    assign current_24_min  = r_min;
    assign current_24_hour = r_hour;
    assign timer_min       = r_tmr_min;
    assign timer_sec       = r_tmr_sec;
    assign timer_running   = r_tmr_running;
    assign timer_buzzer    = r_tmr_buzzer;
    assign alarm_buzzer    = r_alarm_buzzer;

endmodule

// File: tb/tb_main_driver.sv
// Directed and randomized bench for main_driver against a seconds-based reference model.
module tb_main_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hour_format = 1'b0;
  logic        set_time = 1'b0, set_date = 1'b0, set_alarm = 1'b0, set_timer = 1'b0;
  logic        snooze_alarm = 1'b0, stop_alarm = 1'b0, start_timer = 1'b0, stop_timer = 1'b0;
  logic [7:0]  input_sec = '0, input_min = '0, input_hour = '0;
  logic [7:0]  input_day = '0, input_month = '0;
  logic [15:0] input_year = '0;
  logic [7:0]  alarm_input_sec = '0, alarm_input_min = '0, alarm_input_hour = '0;
  logic [7:0]  timer_input_min = '0, timer_input_sec = '0;
  logic [7:0]  current_24_sec, current_24_min, current_24_hour;
  logic [7:0]  display_sec, display_min, display_hour;
  logic [7:0]  current_day, current_month;
  logic [15:0] current_year;
  logic [7:0]  timer_min, timer_sec;
  logic        timer_running, timer_buzzer, alarm_buzzer;

  main_driver #(.SNOOZE_SEC(300), .RESET_YEAR(2000)) dut (
    .clk(clk), .reset(reset), .hour_format(hour_format),
    .set_time(set_time), .set_date(set_date), .set_alarm(set_alarm), .set_timer(set_timer),
    .snooze_alarm(snooze_alarm), .stop_alarm(stop_alarm),
    .start_timer(start_timer), .stop_timer(stop_timer),
    .input_sec(input_sec), .input_min(input_min), .input_hour(input_hour),
    .input_day(input_day), .input_month(input_month), .input_year(input_year),
    .alarm_input_sec(alarm_input_sec), .alarm_input_min(alarm_input_min),
    .alarm_input_hour(alarm_input_hour),
    .timer_input_min(timer_input_min), .timer_input_sec(timer_input_sec),
    .current_24_sec(current_24_sec), .current_24_min(current_24_min),
    .current_24_hour(current_24_hour),
    .display_sec(display_sec), .display_min(display_min), .display_hour(display_hour),
    .current_day(current_day), .current_month(current_month), .current_year(current_year),
    .timer_min(timer_min), .timer_sec(timer_sec), .timer_running(timer_running),
    .timer_buzzer(timer_buzzer), .alarm_buzzer(alarm_buzzer)
  );

  always #5 clk = ~clk;

  // Reference model: time of day and alarm as seconds since midnight, timer as seconds left.
  int m_tod, m_day, m_mon, m_year, m_al, m_tleft;
  bit m_armed, m_abuzz, m_trun, m_tbuzz;
  int n_checks = 0;
  int n_pass = 0;

  function automatic int month_len(int m, int y);
    int len [1:12];
    len = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2)
      return (y % 400 == 0) ? 29 : (y % 100 == 0) ? 28 : (y % 4 == 0) ? 29 : 28;
    return len[m];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_update();
    int  old_tod;
    bit  tick;
    old_tod = m_tod;
    tick = 0;
    if (reset) begin
      m_tod = 0; m_day = 1; m_mon = 1; m_year = 2000;
      m_al = 0; m_armed = 0; m_abuzz = 0;
      m_tleft = 0; m_trun = 0; m_tbuzz = 0;
      return;
    end
    if (set_time && input_hour <= 23 && input_min <= 59 && input_sec <= 59) begin
      m_tod = input_hour * 3600 + input_min * 60 + input_sec;
    end else begin
      m_tod = (old_tod + 1) % 86400;
      tick = (old_tod == 86399);
    end
    if (set_date && input_month >= 1 && input_month <= 12 && input_day >= 1 &&
        int'(input_day) <= month_len(int'(input_month), int'(input_year))) begin
      m_day = input_day; m_mon = input_month; m_year = input_year;
    end else if (tick) begin
      m_day++;
      if (m_day > month_len(m_mon, m_year)) begin
        m_day = 1;
        m_mon++;
        if (m_mon > 12) begin m_mon = 1; m_year++; end
      end
    end
    if (set_alarm && alarm_input_hour <= 23 && alarm_input_min <= 59 && alarm_input_sec <= 59) begin
      m_al = alarm_input_hour * 3600 + alarm_input_min * 60 + alarm_input_sec;
      m_armed = 1; m_abuzz = 0;
    end else if (stop_alarm) begin
      m_armed = 0; m_abuzz = 0;
    end else if (snooze_alarm && m_abuzz) begin
      m_abuzz = 0;
      m_al = (old_tod + 300) % 86400;
    end else if (m_armed && old_tod == m_al) begin
      m_abuzz = 1;
    end
    if (set_timer && timer_input_min <= 99 && timer_input_sec <= 59) begin
      m_tleft = timer_input_min * 60 + timer_input_sec;
      m_trun = 0; m_tbuzz = 0;
    end else if (stop_timer) begin
      m_trun = 0; m_tbuzz = 0;
    end else if (m_trun) begin
      m_tleft--;
      if (m_tleft == 0) begin m_trun = 0; m_tbuzz = 1; end
    end else if (start_timer && m_tleft != 0) begin
      m_trun = 1;
    end
  endtask

  task automatic check_all();
    int h, h12;
    h = m_tod / 3600;
    h12 = (h % 12 == 0) ? 12 : h % 12;
    chk("hour", current_24_hour, h);
    chk("min", current_24_min, (m_tod / 60) % 60);
    chk("sec", current_24_sec, m_tod % 60);
    chk("disp_hour", display_hour, hour_format ? h12 : h);
    chk("disp_min", display_min, (m_tod / 60) % 60);
    chk("disp_sec", display_sec, m_tod % 60);
    chk("day", current_day, m_day);
    chk("month", current_month, m_mon);
    chk("year", current_year, m_year);
    chk("timer_min", timer_min, m_tleft / 60);
    chk("timer_sec", timer_sec, m_tleft % 60);
    chk("timer_running", timer_running, m_trun);
    chk("timer_buzzer", timer_buzzer, m_tbuzz);
    chk("alarm_buzzer", alarm_buzzer, m_abuzz);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_strobes();
    reset = 0; set_time = 0; set_date = 0; set_alarm = 0; set_timer = 0;
    snooze_alarm = 0; stop_alarm = 0; start_timer = 0; stop_timer = 0;
  endtask

  task automatic drive_time(input int h, input int m, input int s);
    set_time = 1; input_hour = 8'(h); input_min = 8'(m); input_sec = 8'(s);
  endtask

  task automatic drive_date(input int d, input int m, input int y);
    set_date = 1; input_day = 8'(d); input_month = 8'(m); input_year = 16'(y);
  endtask

  initial begin
    int waited;
    int t;
    #2;
    reset = 1;
    tick(1);
    chk("reset_hour", current_24_hour, 0);
    chk("reset_year", current_year, 2000);
    clear_strobes();

    drive_date(31, 12, 2022); drive_time(23, 59, 58);
    tick(1); clear_strobes(); tick(2);
    chk("ny_sec", current_24_sec, 0);
    chk("ny_hour", current_24_hour, 0);
    chk("ny_day", current_day, 1);
    chk("ny_month", current_month, 1);
    chk("ny_year", current_year, 2023);

    drive_date(28, 2, 2020); drive_time(23, 59, 57);
    tick(1); clear_strobes(); tick(3);
    chk("leap2020_day", current_day, 29);
    chk("leap2020_month", current_month, 2);

    drive_date(28, 2, 2100); drive_time(23, 59, 57);
    tick(1); clear_strobes(); tick(3);
    chk("y2100_day", current_day, 1);
    chk("y2100_month", current_month, 3);

    hour_format = 1;
    drive_time(0, 0, 5); tick(1); clear_strobes();
    chk("h12_midnight", display_hour, 12);
    chk("h12_cur24", current_24_hour, 0);
    drive_time(13, 20, 0); tick(1); clear_strobes();
    chk("h12_13", display_hour, 1);
    chk("h12_cur24_13", current_24_hour, 13);
    hour_format = 0;

    drive_time(0, 0, 20);
    set_alarm = 1; alarm_input_hour = 0; alarm_input_min = 0; alarm_input_sec = 30;
    tick(1); clear_strobes();
    tick(10);
    chk("alarm_pre", alarm_buzzer, 0);
    tick(1);
    chk("alarm_fire", alarm_buzzer, 1);
    tick(5);
    chk("alarm_hold_sec", current_24_sec, 36);
    snooze_alarm = 1; tick(1); clear_strobes();
    chk("snooze_off", alarm_buzzer, 0);
    waited = 0;
    while (waited < 400 && alarm_buzzer !== 1'b1) begin
      step();
      waited++;
    end
    chk("snooze_refire", alarm_buzzer, 1);
    chk("snooze_min", current_24_min, 5);
    chk("snooze_sec", current_24_sec, 37);
    stop_alarm = 1; tick(1); clear_strobes();
    chk("stop_off", alarm_buzzer, 0);
    tick(400);
    chk("stop_stays", alarm_buzzer, 0);

    set_timer = 1; timer_input_min = 0; timer_input_sec = 2;
    tick(1); clear_strobes();
    start_timer = 1; tick(1); clear_strobes();
    chk("tmr_run", timer_running, 1);
    tick(1);
    chk("tmr_1", timer_sec, 1);
    tick(1);
    chk("tmr_0", timer_sec, 0);
    chk("tmr_buzz", timer_buzzer, 1);
    chk("tmr_stopped", timer_running, 0);
    stop_timer = 1; tick(1); clear_strobes();
    chk("tmr_stop_buzz", timer_buzzer, 0);

    drive_time(10, 0, 0); tick(1); clear_strobes();
    drive_time(24, 0, 0); tick(1); clear_strobes();
    chk("inv_time_hour", current_24_hour, 10);
    chk("inv_time_sec", current_24_sec, 1);
    drive_date(15, 2, 2021); tick(1); clear_strobes();
    drive_date(30, 2, 2021); tick(1); clear_strobes();
    chk("inv_date_day", current_day, 15);
    chk("inv_date_month", current_month, 2);

    set_timer = 1; timer_input_min = 5; timer_input_sec = 0; tick(1); clear_strobes();
    start_timer = 1; tick(3); clear_strobes();
    reset = 1; tick(1); clear_strobes();
    chk("rst_hour", current_24_hour, 0);
    chk("rst_sec", current_24_sec, 0);
    chk("rst_day", current_day, 1);
    chk("rst_year", current_year, 2000);
    chk("rst_tmr_min", timer_min, 0);
    chk("rst_tmr_run", timer_running, 0);

    for (int n = 0; n < 3000; n++) begin
      clear_strobes();
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 29) == 0) hour_format = ~hour_format;
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 1) drive_time(23, 59, int'($urandom_range(45, 59)));
        else drive_time(int'($urandom_range(0, 25)), int'($urandom_range(0, 61)), int'($urandom_range(0, 61)));
      end
      if ($urandom_range(0, 39) == 0)
        drive_date(int'($urandom_range(25, 32)), int'($urandom_range(0, 13)),
                   int'($urandom_range(0, 3) == 0 ? 2100 : $urandom_range(1999, 2025)));
      if ($urandom_range(0, 59) == 0) begin
        set_alarm = 1;
        if ($urandom_range(0, 3) != 0) begin
          t = (m_tod + int'($urandom_range(1, 20))) % 86400;
          alarm_input_hour = 8'(t / 3600); alarm_input_min = 8'((t / 60) % 60);
          alarm_input_sec = 8'(t % 60);
        end else begin
          alarm_input_hour = 8'($urandom_range(0, 25));
          alarm_input_min = 8'($urandom_range(0, 61));
          alarm_input_sec = 8'($urandom_range(0, 61));
        end
      end
      snooze_alarm = ($urandom_range(0, 19) == 0);
      stop_alarm = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) begin
        set_timer = 1;
        timer_input_min = 8'($urandom_range(0, 7) == 0 ? 100 : $urandom_range(0, 1));
        timer_input_sec = 8'($urandom_range(0, 61));
      end
      start_timer = ($urandom_range(0, 9) == 0);
      stop_timer = ($urandom_range(0, 79) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
